fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side controller for the pre-filled async FIFO.
- Sits in the read (compute) clock domain.
- On a start pulse it waits until the FIFO reports its pre-fill level reached, then pops exactly BURST_LEN words.
- Words go onto a valid/ready stream into the convolution datapath through a 2-entry output buffer, with a last marker, a done pulse and a starvation (underrun) counter.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- BURST_LEN, 64, words popped per start; legal range 1..65535.
- CNT_WIDTH, 16, width of the popped-word and underrun counters.
- WAIT_PREFILL, 1, 1 = hold in WAIT_FILL until fifo_pre_fill_done; 0 = go straight to STREAM.

Ports:
- clk  in  1  single clock, read domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a burst; accepted only in IDLE.
- fifo_rd_en  out  1  pop strobe to FIFO (combinational).
- fifo_rd_data  in  DATA_WIDTH  FIFO head word; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pre_fill_done  in  1  pre-fill flag, already synchronized into clk domain.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks the final word of the burst.
- m_ready  in  1  downstream accept.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- underrun_cnt  out  CNT_WIDTH  count of starved cycles in the current or last burst.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, popped=0, buffer cleared.
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, done=0, underrun_cnt=0.
- fifo_rd_en=0 during reset.
- Reset mid-burst abandons the burst; words already in the buffer are discarded; FIFO contents are untouched.
- States:
  - IDLE: start=1 moves to WAIT_FILL, or to STREAM if WAIT_PREFILL=0. On accepting start, popped and underrun_cnt clear to 0.
  - WAIT_FILL: moves to STREAM on the first cycle fifo_pre_fill_done=1. fifo_rd_en=0 in this state.
  - STREAM: pops words. Moves to FLUSH in the cycle popped reaches BURST_LEN, i.e. the cycle of the final pop.
  - FLUSH: no pops. When the buffer entry carrying m_last is accepted (m_valid&m_ready&m_last), done=1 for that single cycle and state moves to IDLE.
- start outside IDLE is ignored. fifo_pre_fill_done falling after entry to STREAM is ignored.
- Pop rule, fifo_rd_en = STREAM & !fifo_empty & (popped < BURST_LEN) & (occ < 2 | (m_valid & m_ready)).
  - occ is the output buffer occupancy, 0..2.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Latency: a word popped on edge N (fifo_rd_en=1, sampled from fifo_rd_data) is visible on m_data with m_valid=1 after edge N, provided it is at the buffer head.
- Output buffer:
  - 2-entry FIFO; the head drives m_data/m_valid.
  - Order preserved.
  - Simultaneous push and pop keeps occ unchanged.
  - m_data holds its value while m_valid=1 & m_ready=0.
  - m_data is don't-care when m_valid=0.
- m_last is stored per entry and set on the entry of pop number BURST_LEN (popped==BURST_LEN-1 at pop).
- popped is CNT_WIDTH bits, increments by 1 per pop, and never exceeds BURST_LEN.
- underrun_cnt increments in each STREAM cycle with popped<BURST_LEN & fifo_empty=1 & occ=0.
  - Saturates at all-ones.
  - Holds its value in IDLE until the next accepted start.
- BURST_LEN=1: first pop goes directly to FLUSH; that word carries m_last=1.

Test Plan:
- BURST_LEN=4, WAIT_PREFILL=1; FIFO holds 0x11,0x22,0x33,0x44; pre_fill_done held 0 for 5 cycles after start.
  - Required: no fifo_rd_en during those cycles; after pre_fill_done=1 and m_ready=1, stream is 11,22,33,44 with m_last only on 0x44.
  - done pulses 1 cycle on 0x44 accept; busy=0 the next cycle; underrun_cnt=0.
- Back-pressure: BURST_LEN=8, FIFO full with 0..7, m_ready low for 6 cycles.
  - Required: exactly 2 pops then fifo_rd_en=0; m_data stable at 0x00.
  - On release, 0..7 arrive in order with no gaps; total pops=8.
- Underrun: FIFO empty for 3 cycles in STREAM with the buffer drained.
  - Required: underrun_cnt=3; no fifo_rd_en while empty; burst still completes with correct data.
- Start while busy and pre_fill_done toggling mid-burst: both ignored.
  - Required: exactly BURST_LEN pops; one done pulse.
- rst asserted in STREAM with occ=2.
  - Required: next cycle m_valid=0, busy=0, fifo_rd_en=0.
  - A following start runs a full fresh burst with underrun_cnt cleared.
- BURST_LEN=1, WAIT_PREFILL=0, m_ready=1.
  - Required: one pop in the first cycle after start acceptance; that word has m_last=1; done fires on its accept; no second pop.

Source files
------------

// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side controller for the pre-filled async FIFO, clocked in the read
// (compute) domain. A start pulse arms one burst. The block waits for the
// FIFO pre-fill flag (optional), pops exactly BURST_LEN words and forwards
// them through a 2-entry output buffer onto a valid/ready stream. The final
// word carries m_last, and its acceptance produces a one-cycle done pulse.
// STREAM cycles in which the datapath is starved are counted in underrun_cnt.
//
// Ports:
//   clk                 read-domain clock
//   rst                 synchronous reset, active-high
//   start               one-cycle burst request, honoured only in IDLE
//   fifo_rd_en          pop strobe to the FIFO (combinational)
//   fifo_rd_data        FIFO head word (first-word-fall-through)
//   fifo_empty          FIFO empty flag
//   fifo_pre_fill_done  pre-fill level reached (already in clk domain)
//   m_valid/m_data/m_last/m_ready  output stream
//   busy                high in every state except IDLE
//   done                one-cycle pulse when the m_last word is accepted
//   underrun_cnt        starved STREAM cycles of the current/last burst
//   state_dbg           current FSM state (IDLE=0, WAIT_FILL=1, STREAM=2, FLUSH=3)
//
// Stream handshake: a word transfers on every rising edge where
// m_valid=1 and m_ready=1. Once m_valid is raised, m_valid, m_data and
// m_last hold steady until that transfer happens; m_valid never depends
// on m_ready.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int BURST_LEN    = 64,
    parameter int CNT_WIDTH    = 16,
    parameter int WAIT_PREFILL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_pre_fill_done,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  underrun_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        STREAM    = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  popped;
    logic [CNT_WIDTH-1:0]  underrun_q;

    // Output buffer: two slots addressed by 1-bit read/write pointers.
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    logic                  push;
    logic                  pop;
    logic                  start_acc;
    logic                  last_pop;
    logic                  starve;

    assign m_valid      = (occ != 2'd0);
    assign m_data       = buf_data[rd_ptr];
    assign m_last       = m_valid & buf_last[rd_ptr];
    assign busy         = (state != IDLE);
    assign underrun_cnt = underrun_q;
    assign state_dbg    = state;

    assign pop       = m_valid & m_ready;
    assign push      = fifo_rd_en;
    assign start_acc = (state == IDLE) & start;
    // The pop that brings popped up to BURST_LEN carries the last marker.
    assign last_pop  = (popped == LAST_IDX);
    // Starved: still owe words, nothing in the FIFO and nothing buffered.
    assign starve    = (state == STREAM) & (popped < BURST_CNT) &
                       fifo_empty & (occ == 2'd0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (WAIT_PREFILL != 0) ? WAIT_FILL : STREAM;
                end
            end
            WAIT_FILL: begin
                if (fifo_pre_fill_done) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                // A full buffer can still take a word when its head leaves
                // in the same cycle, so back-to-back transfers have no gaps.
                fifo_rd_en = !rst & !fifo_empty & (popped < BURST_CNT) &
                             ((occ != 2'd2) | pop);
                if (fifo_rd_en && last_pop) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && m_last) begin
                    done      = !rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            popped     <= '0;
            underrun_q <= '0;
        end else if (start_acc) begin
            popped     <= '0;
            underrun_q <= '0;
        end else begin
            if (push) begin
                popped <= popped + 1'b1;
            end
            if (starve && (underrun_q != CNT_MAX)) begin
                underrun_q <= underrun_q + 1'b1;
            end
        end
    end

    // ---------------- output buffer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= 2'b00;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= fifo_rd_data;
                buf_last[wr_ptr] <= last_pop;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule
